// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial SPI sequencer: FSM state encoding,
// configuration write table and rate-register read addresses.
package inert_pkg;

    localparam logic [15:0] INIT_WAIT_DEFAULT = 16'hFFFF;

    localparam logic [15:0] CFG_INT_DRDY = 16'h0D02;
    localparam logic [15:0] CFG_ACCEL    = 16'h1053;
    localparam logic [15:0] CFG_GYRO     = 16'h1150;
    localparam logic [15:0] CFG_ROUND    = 16'h1460;

    localparam logic [7:0] RD_PTCH_L = 8'hA2;
    localparam logic [7:0] RD_PTCH_H = 8'hA3;
    localparam logic [7:0] RD_ROLL_L = 8'hA4;
    localparam logic [7:0] RD_ROLL_H = 8'hA5;
    localparam logic [7:0] RD_YAW_L  = 8'hA6;
    localparam logic [7:0] RD_YAW_H  = 8'hA7;

    typedef enum logic [2:0] {
        PWR_WAIT,
        CFG_ISSUE,
        CFG_WAIT,
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        PUBLISH
    } seq_state_t;

    function automatic logic [15:0] cfg_word(input logic [1:0] idx);
        logic [15:0] w;
        case (idx)
            2'd0:    w = CFG_INT_DRDY;
            2'd1:    w = CFG_ACCEL;
            2'd2:    w = CFG_GYRO;
            default: w = CFG_ROUND;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] rd_addr(input logic [2:0] idx);
        logic [7:0] a;
        case (idx)
            3'd0:    a = RD_PTCH_L;
            3'd1:    a = RD_PTCH_H;
            3'd2:    a = RD_ROLL_L;
            3'd3:    a = RD_ROLL_H;
            3'd4:    a = RD_YAW_L;
            3'd5:    a = RD_YAW_H;
            default: a = RD_PTCH_L;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/inert_spi_seq_int_synch.sv
// Two-flop synchronizer bringing the sensor data-ready interrupt into the clk domain.
module int_synch (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/inert_spi_seq.sv
// Inertial sensor SPI sequencer: power-up wait, configuration writes, then a
// six-byte rate read burst per data-ready interrupt with a one-cycle valid strobe.
module inert_spi_seq
    import inert_pkg::*;
#(
    parameter logic [15:0] INIT_WAIT = INIT_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        init_done,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] roll_rt,
    output logic [15:0] yaw_rt
);

    seq_state_t  state_q;
    logic [15:0] timer_q;
    logic [2:0]  idx_q;
    logic [7:0]  hold_q [6];
    logic        wrt_q;
    logic [15:0] cmd_q;
    logic        init_done_q;
    logic        vld_q;
    logic [15:0] ptch_q;
    logic [15:0] roll_q;
    logic [15:0] yaw_q;
    logic        int_s;
    logic        unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    int_synch u_int_synch (
        .clk (clk),
        .rst (rst),
        .d_i (INT),
        .q_o (int_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PWR_WAIT;
            timer_q     <= '0;
            idx_q       <= '0;
            for (int unsigned i = 0; i < 6; i++) hold_q[i] <= '0;
            wrt_q       <= 1'b0;
            cmd_q       <= '0;
            init_done_q <= 1'b0;
            vld_q       <= 1'b0;
            ptch_q      <= '0;
            roll_q      <= '0;
            yaw_q       <= '0;
        end else begin
            wrt_q <= 1'b0;
            vld_q <= 1'b0;
            case (state_q)
                PWR_WAIT: begin
                    if (timer_q == INIT_WAIT - 16'd1) begin
                        idx_q   <= '0;
                        state_q <= CFG_ISSUE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                CFG_ISSUE: begin
                    wrt_q   <= 1'b1;
                    cmd_q   <= cfg_word(idx_q[1:0]);
                    state_q <= CFG_WAIT;
                end
                CFG_WAIT: begin
                    if (done) begin
                        if (idx_q == 3'd3) begin
                            init_done_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= CFG_ISSUE;
                        end
                    end
                end
                IDLE: begin
                    if (int_s) begin
                        idx_q   <= '0;
                        state_q <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    wrt_q   <= 1'b1;
                    cmd_q   <= {rd_addr(idx_q), 8'h00};
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (done) begin
                        hold_q[idx_q] <= rd_data[7:0];
                        if (idx_q == 3'd5) begin
                            // Rates and vld are registered on entry so they are
                            // visible during the PUBLISH cycle, one cycle after the last done.
                            ptch_q  <= {hold_q[1], hold_q[0]};
                            roll_q  <= {hold_q[3], hold_q[2]};
                            yaw_q   <= {rd_data[7:0], hold_q[4]};
                            vld_q   <= 1'b1;
                            state_q <= PUBLISH;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                PUBLISH: state_q <= IDLE;
                default: state_q <= PWR_WAIT;
            endcase
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign init_done = init_done_q;
    assign vld       = vld_q;
    assign ptch_rt   = ptch_q;
    assign roll_rt   = roll_q;
    assign yaw_rt    = yaw_q;

endmodule

// File: tb/tb_inert_spi_seq.sv
// Directed bench for inert_spi_seq: power-up timing, config writes, read bursts,
// INT handling, spurious done and mid-burst reset against hand-computed values.
module tb_inert_spi_seq;

    logic        clk;
    logic        rst;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        init_done;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] roll_rt;
    logic [15:0] yaw_rt;

    int tests = 0;
    int fails = 0;
    int vld_cnt = 0;

    inert_spi_seq #(.INIT_WAIT(16'd16)) dut (
        .clk       (clk),
        .rst       (rst),
        .INT       (INT),
        .done      (done),
        .rd_data   (rd_data),
        .wrt       (wrt),
        .cmd       (cmd),
        .init_done (init_done),
        .vld       (vld),
        .ptch_rt   (ptch_rt),
        .roll_rt   (roll_rt),
        .yaw_rt    (yaw_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (vld === 1'b1) vld_cnt++;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_wrt(input string tag, input logic [15:0] exp_cmd,
                            input int max_cyc, input int exp_lat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (wrt === 1'b1) seen = 1'b1;
        end
        chk({tag, "_wrt"}, {31'd0, seen}, 32'd1);
        chk({tag, "_cmd"}, {16'd0, cmd}, {16'd0, exp_cmd});
        if (exp_lat > 0) chk({tag, "_lat"}, n, exp_lat);
    endtask

    // Returns at the negedge following the done cycle.
    task automatic answer(input string tag, input logic [15:0] exp_cmd,
                          input logic [7:0] b, input bit pulse_int);
        @(negedge clk);
        chk({tag, "_wrt_1cyc"}, {31'd0, wrt}, 32'd0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (pulse_int && i == 3) INT = 1'b1;
            if (pulse_int && i == 8) INT = 1'b0;
        end
        done = 1'b1;
        rd_data = {8'($urandom_range(255, 0)), b};
        chk({tag, "_cmd_hold"}, {16'd0, cmd}, {16'd0, exp_cmd});
        @(negedge clk);
        done = 1'b0;
        rd_data = 16'h0000;
    endtask

    task automatic cfg_seq(input string tag);
        logic [15:0] cfg [4];
        int wcnt;
        cfg[0] = 16'h0D02;
        cfg[1] = 16'h1053;
        cfg[2] = 16'h1150;
        cfg[3] = 16'h1460;
        wcnt = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (wrt === 1'b1) wcnt++;
            if (n == 5) done = 1'b1;
            if (n == 6) done = 1'b0;
        end
        chk({tag, "_pwr_no_wrt"}, wcnt, 0);
        for (int i = 0; i < 4; i++) begin
            wait_wrt($sformatf("%s_cfg%0d", tag, i), cfg[i], 1, 1);
            chk($sformatf("%s_cfg%0d_initlow", tag, i), {31'd0, init_done}, 32'd0);
            answer($sformatf("%s_cfg%0d", tag, i), cfg[i], 8'h00, 1'b0);
        end
        chk({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
    endtask

    task automatic burst(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                         input logic [7:0] b5, input int first_max, input int first_lat,
                         input logic [15:0] e_p, input logic [15:0] e_r, input logic [15:0] e_y);
        logic [7:0] bs [6];
        logic [15:0] c;
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3; bs[4] = b4; bs[5] = b5;
        for (int i = 0; i < 6; i++) begin
            c = {8'hA2 + 8'(i), 8'h00};
            if (i == 0) wait_wrt($sformatf("%s_rd%0d", tag, i), c, first_max, first_lat);
            else        wait_wrt($sformatf("%s_rd%0d", tag, i), c, 1, 1);
            if (i < 5) chk($sformatf("%s_novld%0d", tag, i), {31'd0, vld}, 32'd0);
            answer($sformatf("%s_rd%0d", tag, i), c, bs[i], 1'b0);
        end
        chk({tag, "_vld"}, {31'd0, vld}, 32'd1);
        chk({tag, "_ptch"}, {16'd0, ptch_rt}, {16'd0, e_p});
        chk({tag, "_roll"}, {16'd0, roll_rt}, {16'd0, e_r});
        chk({tag, "_yaw"},  {16'd0, yaw_rt},  {16'd0, e_y});
        @(negedge clk);
        chk({tag, "_vld_1cyc"}, {31'd0, vld}, 32'd0);
        chk({tag, "_ptch_hold"}, {16'd0, ptch_rt}, {16'd0, e_p});
    endtask

    task automatic quiet(input string tag, input int cycles, input bit spur_done);
        int wcnt;
        wcnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (wrt === 1'b1) wcnt++;
            if (spur_done && n == 5) done = 1'b1;
            if (spur_done && n == 6) done = 1'b0;
        end
        chk({tag, "_no_wrt"}, wcnt, 0);
    endtask

    initial begin
        rst = 1'b1;
        INT = 1'b0;
        done = 1'b0;
        rd_data = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_wrt", {31'd0, wrt}, 32'd0);
        chk("rst_cmd", {16'd0, cmd}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_vld", {31'd0, vld}, 32'd0);
        chk("rst_rates", {ptch_rt, roll_rt ^ yaw_rt}, 32'd0);

        // INT already high before configuration completes.
        INT = 1'b1;
        rst = 1'b0;
        cfg_seq("pwrup");

        burst("b1", 8'h01, 8'h80, 8'hFE, 8'hFF, 8'h34, 8'h12, 4, 2,
              16'h8001, 16'hFFFE, 16'h1234);
        chk("b1_vld_cnt", vld_cnt, 1);

        // INT still high on return to IDLE: second burst follows immediately.
        INT = 1'b0;
        burst("b2", 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 4, 2,
              16'h2211, 16'h4433, 16'h6655);
        quiet("after_b2", 30, 1'b1);
        chk("b2_vld_cnt", vld_cnt, 2);

        // Short INT pulse in IDLE starts a burst; a pulse during RD_WAIT is ignored.
        INT = 1'b1;
        @(negedge clk);
        @(negedge clk);
        INT = 1'b0;
        wait_wrt("b3_rd0", 16'hA200, 4, 2);
        answer("b3_rd0", 16'hA200, 8'h00, 1'b0);
        wait_wrt("b3_rd1", 16'hA300, 1, 1);
        answer("b3_rd1", 16'hA300, 8'h7F, 1'b1);
        for (int i = 2; i < 6; i++) begin
            wait_wrt($sformatf("b3_rd%0d", i), {8'hA2 + 8'(i), 8'h00}, 1, 1);
            answer($sformatf("b3_rd%0d", i), {8'hA2 + 8'(i), 8'h00}, 8'hA0 + 8'(i), 1'b0);
        end
        chk("b3_vld", {31'd0, vld}, 32'd1);
        chk("b3_ptch", {16'd0, ptch_rt}, 32'h00007F00);
        chk("b3_roll", {16'd0, roll_rt}, 32'h0000A3A2);
        chk("b3_yaw",  {16'd0, yaw_rt},  32'h0000A5A4);
        quiet("after_b3", 30, 1'b0);
        chk("b3_vld_cnt", vld_cnt, 3);

        // Reset during RD_WAIT of the third byte.
        INT = 1'b1;
        @(negedge clk);
        @(negedge clk);
        INT = 1'b0;
        wait_wrt("b4_rd0", 16'hA200, 4, 2);
        answer("b4_rd0", 16'hA200, 8'h55, 1'b0);
        wait_wrt("b4_rd1", 16'hA300, 1, 1);
        answer("b4_rd1", 16'hA300, 8'h66, 1'b0);
        wait_wrt("b4_rd2", 16'hA400, 1, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_wrt", {31'd0, wrt}, 32'd0);
        chk("mid_rst_cmd", {16'd0, cmd}, 32'd0);
        chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
        chk("mid_rst_vld", {31'd0, vld}, 32'd0);
        chk("mid_rst_ptch", {16'd0, ptch_rt}, 32'd0);
        chk("mid_rst_roll", {16'd0, roll_rt}, 32'd0);
        chk("mid_rst_yaw", {16'd0, yaw_rt}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cfg_seq("rerun");
        quiet("after_rerun", 20, 1'b1);
        chk("final_vld_cnt", vld_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
